lsu_mem_master: RTL and testbench

Load/store initiator between the pipeline MEM stage and the word-addressed data memory (single shared address, synchronous word write, combinational read, no byte enables). Converts RV32I byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses. Performs sign/zero extension on loads and read-modify-write for sub-word stores. Detects misaligned and out-of-range accesses, and stalls the pipeline while busy.

---
 rtl/lsu_mem_master.sv | 166 ++++++++++++++++
 tb/tb_lsu_mem_master.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_master.sv
// Load/store initiator between the MEM stage and a word-addressed data memory.
// Turns RV32I byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into word
// accesses. Loads are sign or zero extended. Sub-word stores use a
// read-modify-write sequence. Misaligned, out-of-range and illegal-funct3
// requests finish with resp_err and never touch memory.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   req_*           pipeline request; accepted when req_valid && req_ready
//   resp_*          one-cycle completion pulse with load data / error flag
//   mem_*           data memory port (sync write, combinational read)
module lsu_mem_master #(
  parameter int unsigned MEM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic        mem_write_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {StIdle, StMerge, StResp} state_e;

  // Byte-address limit, widened so MEM_WORDS*4 cannot wrap.
  localparam logic [33:0] MemBytes = 34'(MEM_WORDS) * 34'd4;

  state_e      state_q, state_d;
  logic [31:0] resp_data_q;
  logic        resp_err_q;
  logic [31:0] word_addr_q;
  logic [31:0] merge_q;
  logic [1:0]  off_q;
  logic        half_q;
  logic [15:0] wdata_q;

  logic        accept;
  logic        f3_ok;
  logic        misaligned;
  logic        in_range;
  logic        req_err;
  logic [31:0] req_word;
  logic [31:0] rd_shift;
  logic [31:0] load_ext;
  logic [31:0] merge_word;
  logic        mem_we;

  assign req_word = {2'b00, req_addr[31:2]};
  assign accept   = req_valid && req_ready;
  assign in_range = {2'b00, req_addr} < MemBytes;

  always_comb begin
    f3_ok = 1'b0;
    if (req_we) begin
      f3_ok = req_funct3 inside {3'b000, 3'b001, 3'b010};
    end else begin
      f3_ok = req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    end
  end

  assign misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign req_err    = !f3_ok || misaligned || !in_range;

  // Aligned accesses only, so shifting by the byte offset also selects halves.
  assign rd_shift = mem_read_data >> {req_addr[1:0], 3'b000};

  always_comb begin
    load_ext = 32'h0;
    unique case (req_funct3)
      3'b000:  load_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  load_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b010:  load_ext = rd_shift;
      3'b100:  load_ext = {24'h0, rd_shift[7:0]};
      3'b101:  load_ext = {16'h0, rd_shift[15:0]};
      default: load_ext = 32'h0;
    endcase
  end

  always_comb begin
    merge_word = merge_q;
    if (half_q) begin
      if (off_q[1]) merge_word[31:16] = wdata_q;
      else          merge_word[15:0]  = wdata_q;
    end else begin
      unique case (off_q)
        2'd0: merge_word[7:0]   = wdata_q[7:0];
        2'd1: merge_word[15:8]  = wdata_q[7:0];
        2'd2: merge_word[23:16] = wdata_q[7:0];
        2'd3: merge_word[31:24] = wdata_q[7:0];
      endcase
    end
  end

  always_comb begin
    state_d        = state_q;
    req_ready      = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = word_addr_q;
    mem_write_data = req_wdata;
    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        mem_addr  = req_word;
        if (accept) begin
          state_d = StResp;
          if (!req_err && req_we) begin
            if (req_funct3 == 3'b010) mem_we  = 1'b1;
            else                      state_d = StMerge;
          end
        end
      end
      StMerge: begin
        mem_we         = 1'b1;
        mem_write_data = merge_word;
        state_d        = StResp;
      end
      StResp: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // The state register resets asynchronously, but an accept in IDLE is
  // combinational, so the write strobe is also masked while reset is held.
  assign mem_write_en = mem_we && !rst;

  assign resp_valid = (state_q == StResp);
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      resp_data_q <= 32'h0;
      resp_err_q  <= 1'b0;
      word_addr_q <= 32'h0;
      merge_q     <= 32'h0;
      off_q       <= 2'b00;
      half_q      <= 1'b0;
      wdata_q     <= 16'h0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        word_addr_q <= req_word;
        resp_err_q  <= req_err;
        resp_data_q <= (req_err || req_we) ? 32'h0 : load_ext;
        merge_q     <= mem_read_data;
        off_q       <= req_addr[1:0];
        half_q      <= req_funct3[0];
        wdata_q     <= req_wdata[15:0];
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master with a 4096-word behavioural data memory.
module tb_lsu_mem_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        mem_write_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:4095];
  logic        pl_en = 1'b0;
  logic [11:0] pl_addr = 12'h0;
  logic [31:0] pl_data = 32'h0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_write_en && (mem_addr < 32'd4096)) mem[mem_addr[11:0]] <= mem_write_data;
    if (pl_en) mem[pl_addr] <= pl_data;
  end
  assign mem_read_data = (mem_addr < 32'd4096) ? mem[mem_addr[11:0]] : 32'h0;

  lsu_mem_master #(.MEM_WORDS(4096)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .resp_err       (resp_err),
    .mem_write_en   (mem_write_en),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  // All tasks start and end 1 time unit after a rising edge.
  task automatic poke(input logic [11:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Issues one request and records what happens until the response (5-cycle bound).
  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] data, output logic err,
                        output int lat, output int nwr, output logic wr_acc,
                        output logic [31:0] wa, output logic [31:0] wdat,
                        output logic rdy_busy);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    data = 32'h0; err = 1'b0; lat = 0; nwr = 0; wr_acc = 1'b0;
    wa = 32'h0; wdat = 32'h0; rdy_busy = 1'b0;
    #4;
    if (mem_write_en) begin nwr++; wr_acc = 1'b1; wa = mem_addr; wdat = mem_write_data; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      #4;
      if (mem_write_en) begin nwr++; wa = mem_addr; wdat = mem_write_data; end
      if (resp_valid) begin lat = i; data = resp_data; err = resp_err; end
      else if (req_ready) rdy_busy = 1'b1;
      @(posedge clk); #1;
      if (lat != 0) break;
    end
  endtask

  task automatic test_reset();
    #2;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
    checks++; if (resp_data !== 32'h0) begin errors++; $display("FAIL reset_resp_data got %h want 0", resp_data); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err got %b want 0", resp_err); end
    checks++; if (mem_write_en !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b want 0", mem_write_en); end
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", req_ready); end
  endtask

  task automatic test_loads();
    logic [31:0] d, wa, wd; logic e, wacc, rb; int lat, nwr;
    logic [2:0]  f3 [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] ad [4] = '{32'h14, 32'h15, 32'h16, 32'h16};
    logic [31:0] ex [4] = '{32'hFFFF_FFFF, 32'h0000_00F0, 32'hFFFF_8070, 32'h0000_8070};
    poke(12'd5, 32'h8070_F0FF);
    for (int i = 0; i < 4; i++) begin
      access(1'b0, f3[i], ad[i], 32'h0, d, e, lat, nwr, wacc, wa, wd, rb);
      checks++; if (d !== ex[i]) begin errors++; $display("FAIL load%0d_data got %h want %h", i, d, ex[i]); end
      checks++; if (lat !== 1 || e !== 1'b0 || nwr !== 0) begin errors++;
        $display("FAIL load%0d_timing lat %0d err %b writes %0d want 1 0 0", i, lat, e, nwr); end
    end
    checks++; if (resp_data !== 32'h0000_8070) begin errors++; $display("FAIL load_hold got %h want 00008070", resp_data); end
  endtask

  task automatic test_word_store();
    logic [31:0] d, wa, wd; logic e, wacc, rb; int lat, nwr;
    access(1'b1, 3'b010, 32'h20, 32'hDEAD_BEEF, d, e, lat, nwr, wacc, wa, wd, rb);
    checks++; if (wacc !== 1'b1 || wa !== 32'd8 || wd !== 32'hDEAD_BEEF || nwr !== 1) begin errors++;
      $display("FAIL sw_write acc %b addr %h data %h n %0d want 1 8 deadbeef 1", wacc, wa, wd, nwr); end
    checks++; if (lat !== 1 || e !== 1'b0 || d !== 32'h0) begin errors++;
      $display("FAIL sw_resp lat %0d err %b data %h want 1 0 0", lat, e, d); end
    access(1'b0, 3'b010, 32'h20, 32'h0, d, e, lat, nwr, wacc, wa, wd, rb);
    checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_after_sw got %h want deadbeef", d); end
  endtask

  task automatic test_subword_store();
    logic [31:0] d, wa, wd; logic e, wacc, rb; int lat, nwr;
    access(1'b1, 3'b000, 32'h21, 32'h0000_0055, d, e, lat, nwr, wacc, wa, wd, rb);
    checks++; if (wacc !== 1'b0 || nwr !== 1 || wa !== 32'd8 || wd !== 32'hDEAD_55EF) begin errors++;
      $display("FAIL sb_write acc %b n %0d addr %h data %h want 0 1 8 dead55ef", wacc, nwr, wa, wd); end
    checks++; if (lat !== 2 || rb !== 1'b0 || e !== 1'b0) begin errors++;
      $display("FAIL sb_timing lat %0d ready_busy %b err %b want 2 0 0", lat, rb, e); end
    access(1'b1, 3'b001, 32'h22, 32'h0000_1234, d, e, lat, nwr, wacc, wa, wd, rb);
    checks++; if (wd !== 32'h1234_55EF || lat !== 2 || nwr !== 1) begin errors++;
      $display("FAIL sh_write data %h lat %0d n %0d want 123455ef 2 1", wd, lat, nwr); end
    checks++; if (mem[8] !== 32'h1234_55EF) begin errors++; $display("FAIL sh_mem got %h want 123455ef", mem[8]); end
  endtask

  task automatic test_errors();
    logic [31:0] d, wa, wd; logic e, wacc, rb; int lat, nwr;
    logic        we [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [2:0]  f3 [4] = '{3'b010, 3'b001, 3'b010, 3'b011};
    logic [31:0] ad [4] = '{32'h22, 32'h03, 32'h4000, 32'h14};
    poke(12'd0, 32'h0102_0304);
    for (int i = 0; i < 4; i++) begin
      access(we[i], f3[i], ad[i], 32'hFFFF_FFFF, d, e, lat, nwr, wacc, wa, wd, rb);
      checks++; if (e !== 1'b1 || d !== 32'h0 || lat !== 1 || nwr !== 0) begin errors++;
        $display("FAIL err%0d err %b data %h lat %0d writes %0d want 1 0 1 0", i, e, d, lat, nwr); end
    end
    checks++; if (mem[8] !== 32'h1234_55EF || mem[0] !== 32'h0102_0304 || mem[5] !== 32'h8070_F0FF) begin
      errors++; $display("FAIL err_mem_intact got %h %h %h", mem[8], mem[0], mem[5]); end
  endtask

  task automatic test_reset_in_merge();
    logic [31:0] d, wa, wd; logic e, wacc, rb; int lat, nwr;
    req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h21; req_wdata = 32'h55; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++; if (mem_write_en !== 1'b1) begin errors++; $display("FAIL merge_reached got %b want 1", mem_write_en); end
    #1 rst = 1'b1;
    #1;
    checks++; if (mem_write_en !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_data !== 32'h0)
      begin errors++; $display("FAIL async_reset we %b rv %b rdy %b data %h want 0 0 1 0",
                               mem_write_en, resp_valid, req_ready, resp_data); end
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (mem[8] !== 32'h1234_55EF) begin errors++; $display("FAIL abort_mem got %h want 123455ef", mem[8]); end
    access(1'b0, 3'b010, 32'h20, 32'h0, d, e, lat, nwr, wacc, wa, wd, rb);
    checks++; if (d !== 32'h1234_55EF || lat !== 1) begin errors++;
      $display("FAIL lw_after_abort got %h lat %0d want 123455ef 1", d, lat); end
  endtask

  task automatic test_back_to_back();
    logic        we [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0]  f3 [6] = '{3'b010, 3'b000, 3'b010, 3'b000, 3'b010, 3'b000};
    logic [31:0] ad [6] = '{32'h28, 32'h28, 32'h28, 32'h29, 32'h28, 32'h2B};
    logic [31:0] wd [6] = '{32'h0, 32'h11, 32'h0, 32'h22, 32'h0, 32'h33};
    logic [31:0] ex [6] = '{32'hAABB_CCDD, 32'h0, 32'hAABB_CC11, 32'h0, 32'hAABB_2211, 32'h0};
    int acc = 0, rsp = 0, extra = 0;
    logic a;
    poke(12'd10, 32'hAABB_CCDD);
    for (int c = 0; c < 60 && rsp < 6; c++) begin
      if (acc < 6) begin
        req_valid = 1'b1; req_we = we[acc]; req_funct3 = f3[acc];
        req_addr = ad[acc]; req_wdata = wd[acc];
      end else req_valid = 1'b0;
      #4;
      if (resp_valid) begin
        checks++; if (resp_data !== ex[rsp] || resp_err !== 1'b0) begin errors++;
          $display("FAIL b2b_resp%0d got %h err %b want %h 0", rsp, resp_data, resp_err, ex[rsp]); end
        rsp++;
      end
      a = req_valid && req_ready;
      @(posedge clk); #1;
      if (a) acc++;
    end
    req_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #4; if (resp_valid) extra++;
      @(posedge clk); #1;
    end
    checks++; if (acc !== 6 || rsp !== 6 || extra !== 0) begin errors++;
      $display("FAIL b2b_counts acc %0d rsp %0d extra %0d want 6 6 0", acc, rsp, extra); end
    checks++; if (mem[10] !== 32'h33BB_2211) begin errors++; $display("FAIL b2b_mem got %h want 33bb2211", mem[10]); end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_word_store();
    test_subword_store();
    test_errors();
    test_reset_in_merge();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
